// File: rtl/dsram_axil_bridge.sv
// Converts single-cycle data-SRAM requests into AXI4-Lite read/write transactions,
// stalling the pipeline until each completes; includes a timeout and a sticky bus error.
module dsram_axil_bridge #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dsram_e,
   input  logic              dsram_we,
   input  logic [63:0]       dsram_addr,
   input  logic [63:0]       dsram_wdata,
   input  logic [7:0]        dsram_sel,
   output logic [63:0]       dsram_rdata,
   output logic              stallreq_mem,
   output logic              bus_err,
   output logic              arvalid,
   input  logic              arready,
   output logic [ADDR_W-1:0] araddr,
   input  logic              rvalid,
   output logic              rready,
   input  logic [63:0]       rdata,
   input  logic [1:0]        rresp,
   output logic              awvalid,
   input  logic              awready,
   output logic [ADDR_W-1:0] awaddr,
   output logic              wvalid,
   input  logic              wready,
   output logic [63:0]       wdata,
   output logic [7:0]        wstrb,
   input  logic              bvalid,
   output logic              bready,
   input  logic [1:0]        bresp
);
   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

   // Abort fires on the edge that would bring the counter up to TIMEOUT.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t              state_reg, state_next;
   logic [7:0]          tmo_cnt_reg, tmo_cnt_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [63:0]         wdata_reg, wdata_next;
   logic [7:0]          sel_reg, sel_next;
   logic [63:0]         dsram_rdata_reg, dsram_rdata_next;
   logic                arvalid_reg, arvalid_next;
   logic                rready_reg, rready_next;
   logic                awvalid_reg, awvalid_next;
   logic                wvalid_reg, wvalid_next;
   logic                bready_reg, bready_next;
   logic                aw_done_reg, aw_done_next;
   logic                w_done_reg, w_done_next;
   logic                bus_err_reg, bus_err_next;
   logic                aw_hs, w_hs, waiting;

   generate
      if (ADDR_W < 64) begin : g_unused_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^dsram_addr[63:ADDR_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         tmo_cnt_reg     <= '0;
         dsram_rdata_reg <= '0;
         arvalid_reg     <= 1'b0;
         rready_reg      <= 1'b0;
         awvalid_reg     <= 1'b0;
         wvalid_reg      <= 1'b0;
         bready_reg      <= 1'b0;
         aw_done_reg     <= 1'b0;
         w_done_reg      <= 1'b0;
         bus_err_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         tmo_cnt_reg     <= tmo_cnt_next;
         dsram_rdata_reg <= dsram_rdata_next;
         arvalid_reg     <= arvalid_next;
         rready_reg      <= rready_next;
         awvalid_reg     <= awvalid_next;
         wvalid_reg      <= wvalid_next;
         bready_reg      <= bready_next;
         aw_done_reg     <= aw_done_next;
         w_done_reg      <= w_done_next;
         bus_err_reg     <= bus_err_next;
      end
   end

   // Request payload needs no reset; it is only observed while a valid is up.
   always_ff @(posedge clk) begin
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      sel_reg   <= sel_next;
   end

   always_comb begin
      state_next       = state_reg;
      tmo_cnt_next     = tmo_cnt_reg;
      addr_next        = addr_reg;
      wdata_next       = wdata_reg;
      sel_next         = sel_reg;
      dsram_rdata_next = dsram_rdata_reg;
      arvalid_next     = arvalid_reg;
      rready_next      = rready_reg;
      awvalid_next     = awvalid_reg;
      wvalid_next      = wvalid_reg;
      bready_next      = bready_reg;
      aw_done_next     = aw_done_reg;
      w_done_next      = w_done_reg;
      bus_err_next     = bus_err_reg;
      aw_hs            = awvalid_reg && awready;
      w_hs             = wvalid_reg && wready;
      waiting          = (state_reg != IDLE) && (state_reg != DONE);

      case (state_reg)
         IDLE: begin
            if (dsram_e) begin
               addr_next    = dsram_addr[ADDR_W-1:0];
               wdata_next   = dsram_wdata;
               sel_next     = dsram_sel;
               tmo_cnt_next = '0;
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               if (dsram_we) begin
                  awvalid_next = 1'b1;
                  wvalid_next  = 1'b1;
                  state_next   = WR_AW;
               end else begin
                  arvalid_next = 1'b1;
                  state_next   = RD_A;
               end
            end
         end
         RD_A: begin
            if (arready) begin
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
               state_next   = RD_D;
            end
         end
         RD_D: begin
            if (rvalid) begin
               dsram_rdata_next = rdata;
               rready_next      = 1'b0;
               if (rresp != 2'b00) bus_err_next = 1'b1;
               state_next       = DONE;
            end
         end
         WR_AW: begin
            if (aw_hs) begin
               awvalid_next = 1'b0;
               aw_done_next = 1'b1;
            end
            if (w_hs) begin
               wvalid_next = 1'b0;
               w_done_next = 1'b1;
            end
            if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
               bready_next = 1'b1;
               state_next  = WR_B;
            end
         end
         WR_B: begin
            if (bvalid) begin
               bready_next = 1'b0;
               if (bresp != 2'b00) bus_err_next = 1'b1;
               state_next  = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Timeout overrides whatever the bus did this cycle.
      if (waiting) begin
         tmo_cnt_next = tmo_cnt_reg + 8'd1;
         if (tmo_cnt_reg >= TMO_LAST) begin
            arvalid_next = 1'b0;
            rready_next  = 1'b0;
            awvalid_next = 1'b0;
            wvalid_next  = 1'b0;
            bready_next  = 1'b0;
            bus_err_next = 1'b1;
            state_next   = DONE;
            if (state_reg == RD_A || state_reg == RD_D) dsram_rdata_next = '0;
         end
      end
   end

   assign stallreq_mem = (state_reg == IDLE && dsram_e) ||
                         (state_reg != IDLE && state_reg != DONE);
   assign dsram_rdata  = dsram_rdata_reg;
   assign bus_err      = bus_err_reg;
   assign arvalid      = arvalid_reg;
   assign araddr       = addr_reg;
   assign rready       = rready_reg;
   assign awvalid      = awvalid_reg;
   assign awaddr       = addr_reg;
   assign wvalid       = wvalid_reg;
   assign wdata        = wdata_reg;
   assign wstrb        = sel_reg;
   assign bready       = bready_reg;
endmodule

// File: tb/tb_dsram_axil_bridge.sv
// Directed bench for dsram_axil_bridge: a vector table of single transactions against a
// latency-configurable AXI4-Lite slave, plus back-to-back and mid-transaction reset sequences.
module tb_dsram_axil_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dsram_e = 1'b0, dsram_we = 1'b0;
   logic [63:0] dsram_addr = '0, dsram_wdata = '0;
   logic [7:0]  dsram_sel = '0;
   logic [63:0] dsram_rdata;
   logic        stallreq_mem, bus_err;
   logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
   logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
   logic [31:0] araddr, awaddr;
   logic [63:0] rdata = '0, wdata;
   logic [1:0]  rresp = '0, bresp = '0;
   logic [7:0]  wstrb;

   dsram_axil_bridge #(.ADDR_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .dsram_e(dsram_e), .dsram_we(dsram_we),
      .dsram_addr(dsram_addr), .dsram_wdata(dsram_wdata), .dsram_sel(dsram_sel),
      .dsram_rdata(dsram_rdata), .stallreq_mem(stallreq_mem), .bus_err(bus_err),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0;

   // Slave configuration and observation
   int          s_ar_lat = 0, s_r_lat = 0, s_aw_lat = 0, s_w_lat = 0, s_b_lat = 0;
   logic [63:0] s_rdata = '0;
   logic [1:0]  s_resp = '0;
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, wonly_cnt = 0, overlap_cnt = 0;
   logic [31:0] cap_araddr = '0, cap_awaddr = '0;
   logic [63:0] cap_wdata = '0;
   logic [7:0]  cap_wstrb = '0;

   // Readies/valids decided on the falling edge; a ready raised while the valid is up
   // completes a handshake on the next rising edge, so it is counted here.
   initial begin
      forever begin
         @(negedge clk);
         if (arvalid) begin
            if (ar_wait >= s_ar_lat) begin arready = 1'b1; ar_cnt++; cap_araddr = araddr; end
            else begin arready = 1'b0; ar_wait++; end
         end else begin arready = 1'b0; ar_wait = 0; end
         if (rready) begin
            if (r_wait >= s_r_lat) begin rvalid = 1'b1; rdata = s_rdata; rresp = s_resp; end
            else begin rvalid = 1'b0; r_wait++; end
         end else begin rvalid = 1'b0; r_wait = 0; end
         if (awvalid) begin
            if (aw_wait >= s_aw_lat) begin awready = 1'b1; aw_cnt++; cap_awaddr = awaddr; end
            else begin awready = 1'b0; aw_wait++; end
         end else begin awready = 1'b0; aw_wait = 0; end
         if (wvalid) begin
            if (w_wait >= s_w_lat) begin
               wready = 1'b1; w_cnt++; cap_wdata = wdata; cap_wstrb = wstrb;
            end else begin wready = 1'b0; w_wait++; end
         end else begin wready = 1'b0; w_wait = 0; end
         if (bready) begin
            if (b_wait >= s_b_lat) begin bvalid = 1'b1; bresp = s_resp; end
            else begin bvalid = 1'b0; b_wait++; end
         end else begin bvalid = 1'b0; b_wait = 0; end
         if (awvalid && !wvalid) wonly_cnt++;
         if (bready && (awvalid || wvalid)) overlap_cnt++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      dsram_e = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [63:0] addr, wdat;
      logic [7:0]  sel;
      logic [63:0] rdat;
      logic [1:0]  resp;
      int          ar_lat, r_lat, aw_lat, w_lat, b_lat;
      logic        rst_before;
      int          exp_stalls;
      logic [63:0] exp_rdata;
      logic        exp_err;
      int          exp_ar, exp_aw, exp_wonly;
   } vec_t;

   vec_t vecs[11];

   // Issue one request and run it to its DONE cycle; returns the number of stalled cycles.
   task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                        input logic [7:0] sel, output int stalls);
      @(negedge clk);
      dsram_e = 1'b1; dsram_we = we; dsram_addr = addr; dsram_wdata = wd; dsram_sel = sel;
      #1;
      stalls = 0;
      while (stallreq_mem && stalls < 40) begin
         stalls++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int stalls, ar0, aw0, w0, wo0;
      if (v.rst_before) do_reset();
      s_ar_lat = v.ar_lat; s_r_lat = v.r_lat; s_aw_lat = v.aw_lat;
      s_w_lat = v.w_lat; s_b_lat = v.b_lat; s_rdata = v.rdat; s_resp = v.resp;
      ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt; wo0 = wonly_cnt;
      issue(v.we, v.addr, v.wdat, v.sel, stalls);
      chk($sformatf("v%0d stall_cycles", idx), 64'(stalls), 64'(v.exp_stalls));
      chk($sformatf("v%0d dsram_rdata", idx), dsram_rdata, v.exp_rdata);
      chk($sformatf("v%0d bus_err", idx), 64'(bus_err), 64'(v.exp_err));
      chk($sformatf("v%0d valids_in_done", idx), 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
      chk($sformatf("v%0d ar_handshakes", idx), 64'(ar_cnt - ar0), 64'(v.exp_ar));
      chk($sformatf("v%0d aw_handshakes", idx), 64'(aw_cnt - aw0), 64'(v.exp_aw));
      chk($sformatf("v%0d w_handshakes", idx), 64'(w_cnt - w0), 64'(v.exp_aw));
      chk($sformatf("v%0d aw_only_cycles", idx), 64'(wonly_cnt - wo0), 64'(v.exp_wonly));
      if (v.exp_ar > 0) chk($sformatf("v%0d araddr", idx), 64'(cap_araddr), 64'(v.addr[31:0]));
      if (v.exp_aw > 0) begin
         chk($sformatf("v%0d awaddr", idx), 64'(cap_awaddr), 64'(v.addr[31:0]));
         chk($sformatf("v%0d wdata", idx), cap_wdata, v.wdat);
         chk($sformatf("v%0d wstrb", idx), 64'(cap_wstrb), 64'(v.sel));
      end
      $display("vec %0d: we=%0b addr=0x%0h stalls=%0d rdata=0x%0h bus_err=%0b",
               idx, v.we, v.addr, stalls, dsram_rdata, bus_err);
      @(negedge clk);
      dsram_e = 1'b0;
   endtask

   initial begin
      int stalls, ar0, aw0, w0, k;
      //          we    addr                 wdat                    sel    rdat                    resp   ar  r  aw w  b  rstb  stl exp_rdata                  err   ar aw wo
      vecs[0]  = '{1'b0, 64'h8000_0010,      64'h0,                  8'h00, 64'h1122334455667788, 2'b00, 0, 0, 0, 0, 0, 1'b0, 3, 64'h1122334455667788, 1'b0, 1, 0, 0};
      vecs[1]  = '{1'b1, 64'h8000_0100,      64'hAABBCCDD,           8'h0F, 64'h0,                2'b00, 0, 0, 3, 0, 0, 1'b0, 6, 64'h1122334455667788, 1'b0, 0, 1, 3};
      vecs[2]  = '{1'b0, 64'h0000_0020,      64'h0,                  8'h00, 64'hDEADBEEFCAFEF00D, 2'b00, 2, 1, 0, 0, 0, 1'b0, 6, 64'hDEADBEEFCAFEF00D, 1'b0, 1, 0, 0};
      vecs[3]  = '{1'b0, 64'h0000_0028,      64'h0,                  8'h00, 64'h55,               2'b10, 0, 0, 0, 0, 0, 1'b0, 3, 64'h55,               1'b1, 1, 0, 0};
      vecs[4]  = '{1'b1, 64'h0000_0030,      64'h123456789ABCDEF0,   8'hFF, 64'h0,                2'b00, 0, 0, 0, 0, 0, 1'b0, 3, 64'h55,               1'b1, 0, 1, 0};
      vecs[5]  = '{1'b0, 64'h0000_0038,      64'h0,                  8'h00, 64'h66,               2'b00, 0, 0, 0, 0, 0, 1'b0, 3, 64'h66,               1'b1, 1, 0, 0};
      vecs[6]  = '{1'b1, 64'h0000_0040,      64'h77,                 8'h01, 64'h0,                2'b00, 0, 0, 0, 0, 2, 1'b0, 5, 64'h66,               1'b1, 0, 1, 0};
      vecs[7]  = '{1'b1, 64'h0000_0050,      64'h99,                 8'h80, 64'h0,                2'b11, 0, 0, 0, 0, 0, 1'b1, 3, 64'h0,                1'b1, 0, 1, 0};
      vecs[8]  = '{1'b1, 64'h0000_0054,      64'h0102030405060708,   8'h3C, 64'h0,                2'b00, 0, 0, 0, 2, 0, 1'b1, 5, 64'h0,                1'b0, 0, 1, 0};
      vecs[9]  = '{1'b0, 64'h0000_0058,      64'h0,                  8'h00, 64'hA5A5A5A5A5A5A5A5, 2'b00, 0, 0, 0, 0, 0, 1'b0, 3, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1, 0, 0};
      vecs[10] = '{1'b0, 64'h0000_0060,      64'h0,                  8'h00, 64'hFFFF,             2'b00, 255, 0, 0, 0, 0, 1'b0, 9, 64'h0,              1'b1, 0, 0, 0};

      repeat (2) @(negedge clk);
      #1;
      chk("reset dsram_rdata", dsram_rdata, 64'd0);
      chk("reset bus_err", 64'(bus_err), 64'd0);
      chk("reset stallreq_mem", 64'(stallreq_mem), 64'd0);
      chk("reset valids_readies", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Back-to-back read then write: the held request during DONE must not re-issue.
      do_reset();
      s_ar_lat = 0; s_r_lat = 0; s_aw_lat = 0; s_w_lat = 0; s_b_lat = 0;
      s_resp = 2'b00; s_rdata = 64'h0F0F0F0F0F0F0F0F;
      ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
      issue(1'b0, 64'h100, 64'h0, 8'h00, stalls);
      chk("b2b read stalls", 64'(stalls), 64'd3);
      issue(1'b1, 64'h108, 64'hBEEF, 8'h03, stalls);
      chk("b2b write stalls", 64'(stalls), 64'd3);
      @(negedge clk);
      dsram_e = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b ar_handshakes", 64'(ar_cnt - ar0), 64'd1);
      chk("b2b aw_handshakes", 64'(aw_cnt - aw0), 64'd1);
      chk("b2b w_handshakes", 64'(w_cnt - w0), 64'd1);
      chk("b2b dsram_rdata", dsram_rdata, 64'h0F0F0F0F0F0F0F0F);
      $display("seq b2b: ar=%0d aw=%0d w=%0d rdata=0x%0h", ar_cnt - ar0, aw_cnt - aw0, w_cnt - w0, dsram_rdata);

      // Reset while waiting in the data phase of a read.
      s_r_lat = 255;
      @(negedge clk);
      dsram_e = 1'b1; dsram_we = 1'b0; dsram_addr = 64'h200;
      #1;
      k = 0;
      while (!rready && k < 20) begin
         k++;
         @(negedge clk);
         #1;
      end
      chk("rstmid reached rd_d", 64'(rready), 64'd1);
      chk("rstmid rdata before", dsram_rdata, 64'h0F0F0F0F0F0F0F0F);
      rst = 1'b1;
      dsram_e = 1'b0;
      @(posedge clk);
      #1;
      chk("rstmid rready", 64'(rready), 64'd0);
      chk("rstmid stallreq_mem", 64'(stallreq_mem), 64'd0);
      chk("rstmid dsram_rdata", dsram_rdata, 64'd0);
      chk("rstmid arvalid", 64'(arvalid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("seq rst_in_rd_d: rready=%0b stall=%0b rdata=0x%0h", rready, stallreq_mem, dsram_rdata);

      chk("bready overlapping aw/w valid", 64'(overlap_cnt), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
